vga_timing_out: RTL
===================

VGA_TIMING_OUT -- requirements
Module: vga_timing_out

Interface
REQ-001 Parameter: RENDER_LAT, 0, renderer latency in pixel ticks from pixel_x/pixel_y to matching rgb_*_in (legal 0..3).
REQ-002 Parameter: H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels.
REQ-003 Parameter: V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.
REQ-004 clk  in  1  system clock; the block has one clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pix_en  in  1  pixel-tick enable (one clk cycle in two at 50 MHz); all timing state advances only when high.
REQ-007 rgb_r_in, rgb_g_in, rgb_b_in  in  8 each  composited colour for the coordinate issued RENDER_LAT ticks earlier.
REQ-008 pixel_x  out  10  current horizontal count, to renderers.
REQ-009 pixel_y  out  10  current vertical count, to renderers.
REQ-010 active  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE (undelayed).
REQ-011 frame_start  out  1  one-clk pulse at frame wrap, for game-state update.
REQ-012 VGA_R, VGA_G, VGA_B  out  8 each  registered pin colour.
REQ-013 VGA_HS, VGA_VS  out  1  active-low syncs; VGA_BLANK_N  out  1  low during blanking; VGA_SYNC_N  out  1  tied low.

Function
REQ-014 h_cnt SHALL count 0..H_TOTAL-1 (800) on each pix_en, wrapping to 0; v_cnt SHALL increment only on h_cnt wrap, range 0..V_TOTAL-1 (525), wrapping to 0.
REQ-015 pixel_x/pixel_y SHALL equal h_cnt/v_cnt directly from registers (no combinational path from inputs).
REQ-016 Raw hsync SHALL be low for h_cnt in [656,751]; raw vsync SHALL be low for v_cnt in [490,491]; raw blank when not active.
REQ-017 Raw hsync, vsync, blank SHALL pass through a delay line of RENDER_LAT+1 pix_en-qualified stages before driving pins.
REQ-018 On pix_en, VGA_R/G/B SHALL load rgb_*_in, or 0 when the delayed blank (aligned to that pixel) is set; total coordinate-to-pin latency = RENDER_LAT+1 ticks for colour and sync alike.
REQ-019 frame_start SHALL be high for exactly one clk cycle: the cycle where pix_en=1, h_cnt=799, v_cnt=524.
REQ-020 When pix_en=0 all counters, delay stages and pin registers SHALL hold; frame_start SHALL be 0.
REQ-021 Boundaries: h wrap at 799->0 and v wrap at 524->0 in the same tick SHALL both occur; no glitch on VGA_HS/VS between ticks.
REQ-022 Input colour outside the active window SHALL never reach the pins (blank forces 0 regardless of rgb_*_in).

Reset
REQ-023 reset asserted SHALL immediately force h_cnt=v_cnt=0, all delay stages to inactive (HS=1, VS=1, BLANK_N=0), VGA_R/G/B=0, frame_start=0.
REQ-024 Reset mid-frame SHALL restart timing at (0,0) on release without a frame_start pulse; first pulse occurs at the first natural wrap.

Structure
REQ-025 Timing constants and derived H_TOTAL=800, V_TOTAL=525, sync start/end values SHALL live in shared package vga_timing_pkg for reuse by renderers.
REQ-026 One sub-module SHALL be used: vga_delay_line (parameterised width, depth, reset value, enable) for the sync/blank pipeline.
REQ-027 Colour compositing stays outside this block; this block only samples the composited bus.

Verification
REQ-028 Reset, release, count pix_en ticks -> first VGA_HS fall exactly 656+RENDER_LAT+1 ticks after release; low for 96 ticks.
REQ-029 Run one full frame (420000 ticks) -> exactly one frame_start, VGA_VS low for 1600 ticks, 307200 ticks with VGA_BLANK_N=1.
REQ-030 RENDER_LAT=2, model renderer returning R=pixel_x[7:0] delayed 2 ticks -> VGA_R equals x of pixel whose blank/sync are on pins that tick, all 640 columns.
REQ-031 rgb_*_in held at 8'hFF constantly -> VGA_R/G/B=0 whenever VGA_BLANK_N=0, 8'hFF otherwise.
REQ-032 Assert reset at h=300,v=200 for 3 clk -> outputs at reset values immediately; after release pixel_x=0, pixel_y=0, no frame_start until 420000 ticks later.
REQ-033 pix_en held low 1000 cycles mid-line -> all outputs frozen, then resume from identical counts.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync/blank bundle type.
// Renderers import this package as well as vga_timing_out.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    // Pin-level idle: syncs deasserted (high), picture blanked.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Enable-qualified shift register with a reset value; q is the full-depth
// output, q_early is one stage earlier (d itself when DEPTH is 1).
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_early
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_one
            assign q_early = d;
        end else begin : g_many
            assign q_early = stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_out.sv
// VGA raster counters plus pin stage: syncs/blank delayed to line up with
// the renderer latency, colour registered and forced to zero while blanked.
module vga_timing_out
    import vga_timing_pkg::*;
#(
    parameter int RENDER_LAT = 0,
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic [7:0]         rgb_r_in,
    input  logic [7:0]         rgb_g_in,
    input  logic [7:0]         rgb_b_in,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               active,
    output logic               frame_start,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N
);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_HI  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_HI  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_last;
    logic               v_last;
    vga_sync_t          raw_sync;
    vga_sync_t          pin_sync;
    vga_sync_t          aligned_sync;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign frame_start = pix_en && h_last && v_last;

    always_comb begin
        raw_sync         = SYNC_IDLE;
        raw_sync.hs      = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
        raw_sync.vs      = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
        raw_sync.blank_n = active;
    end

    // RENDER_LAT+1 stages to the pins; q_early is the blank belonging to
    // the colour currently on the renderer bus.
    vga_delay_line #(
        .WIDTH   ($bits(vga_sync_t)),
        .DEPTH   (RENDER_LAT + 1),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk     (clk),
        .reset   (reset),
        .en      (pix_en),
        .d       (raw_sync),
        .q       (pin_sync),
        .q_early (aligned_sync)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else if (pix_en) begin
            VGA_R <= aligned_sync.blank_n ? rgb_r_in : 8'h00;
            VGA_G <= aligned_sync.blank_n ? rgb_g_in : 8'h00;
            VGA_B <= aligned_sync.blank_n ? rgb_b_in : 8'h00;
        end
    end

    assign VGA_HS      = pin_sync.hs;
    assign VGA_VS      = pin_sync.vs;
    assign VGA_BLANK_N = pin_sync.blank_n;
    assign VGA_SYNC_N  = 1'b0;

endmodule
